// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: the prefetch entry layout and the default prefetch depth.
package cpu_pkg;

  localparam int PREFETCH_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_buffer_if.sv
// Bundle of imem request/response and fetch-stage signals around the prefetch buffer.
interface prefetch_buffer_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_plus4;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data,
    output inst_valid, inst, pc_plus4,
    input  inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data,
    input  inst_valid, inst, pc_plus4,
    output inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and occupancy output; head reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_data = (count == '0) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited imem requests, in-order response capture,
// and redirect flush that drops responses still in flight.
module prefetch_buffer
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = PREFETCH_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  prefetch_buffer_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  // One extra bit: drops from an earlier redirect can coexist with a full new credit window.
  localparam int DW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   push_pc;
  logic [31:0]   redirect_pc_al;
  logic [CW-1:0] occ;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_after;
  logic [DW-1:0] drop;
  logic [DW-1:0] drop_after;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  always_comb begin
    redirect_pc_al = bus.redirect_pc & ~32'h3;
    credit_ok      = ((CW+1)'(occ) + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);
    req_fire       = bus.req_valid && bus.req_ready;
    rsp_keep       = bus.rsp_valid && (drop == '0);
    rsp_drop       = bus.rsp_valid && (drop != '0);
    push           = rsp_keep && !bus.redirect;
    pop            = (occ != '0) && bus.inst_ready && !bus.redirect;
    out_after      = outstanding + CW'(req_fire) - CW'(rsp_keep);
    drop_after     = drop - DW'(rsp_drop);
    push_entry     = '{pc_plus4: push_pc + 32'd4, inst: bus.rsp_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      push_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (bus.redirect) begin
      // A response landing this cycle is already consumed from out_after/drop_after.
      fetch_pc    <= redirect_pc_al;
      push_pc     <= redirect_pc_al;
      outstanding <= '0;
      drop        <= drop_after + DW'(out_after);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push)     push_pc  <= push_pc + 32'd4;
      outstanding <= out_after;
      drop        <= drop_after;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (bus.redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (occ)
  );

  assign bus.req_valid  = !reset && !bus.redirect && credit_ok;
  assign bus.req_addr   = fetch_pc;
  assign bus.inst_valid = (occ != '0);
  assign bus.inst       = head.inst;
  assign bus.pc_plus4   = head.pc_plus4;
endmodule
